// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the MUL/DIV control sequencer: state encoding, datapath
// enable/bus-select bit positions, ALU operation codes and opcodes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6
  } state_t;

  // Register load enable bit positions
  localparam int EN_HI  = 16;
  localparam int EN_LO  = 17;
  localparam int EN_PC  = 20;
  localparam int EN_MDR = 21;
  localparam int EN_IR  = 23;
  localparam int EN_Z   = 24;
  localparam int EN_MAR = 25;
  localparam int EN_Y   = 27;

  // Bus driver select bit positions
  localparam int SEL_ZHI = 18;
  localparam int SEL_ZLO = 19;
  localparam int SEL_PC  = 20;
  localparam int SEL_MDR = 21;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_MUL = 4'd11;
  localparam logic [3:0] ALU_DIV = 4'd12;

  localparam logic [4:0] OPC_MUL_DEFAULT = 5'b01111;
  localparam logic [4:0] OPC_DIV_DEFAULT = 5'b10000;

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index decoder: turns a 4-bit register number into a 16-bit one-hot
// select for the R0-R15 bus drivers.
module reg_onehot_dec (
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_dec
      assign onehot[gi] = (idx == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/muldiv_control_seq.sv
// Fetch/execute sequencer for MUL and DIV: walks T0-T6, driving the datapath's
// enables and bus selects from the current state, and writes the product/quotient into LO/HI.
module muldiv_control_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int         MEM_WAIT_MAX = 15,
  parameter logic [4:0] OPC_MUL      = OPC_MUL_DEFAULT,
  parameter logic [4:0] OPC_DIV      = OPC_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ack,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic        MR_Read,
  output logic [3:0]  Control_Signals,
  output logic        inc_pc,
  output logic        busy,
  output logic        done,
  output logic        illegal_op,
  output logic        mem_err
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        mem_err_q, mem_err_d;

  logic [4:0]  opcode;
  logic        is_mul, is_div, op_legal;
  logic [15:0] ra_onehot, rb_onehot;
  logic [7:0]  wait_next;
  logic        unused_ir_bits;

  assign opcode         = ir[31:27];
  assign is_mul         = (opcode == OPC_MUL);
  assign is_div         = (opcode == OPC_DIV);
  assign op_legal       = is_mul | is_div;
  assign wait_next      = wait_cnt_q + 8'd1;
  assign unused_ir_bits = ^ir[18:0];

  reg_onehot_dec u_ra_dec (
    .idx    (ir[26:23]),
    .onehot (ra_onehot)
  );

  reg_onehot_dec u_rb_dec (
    .idx    (ir[22:19]),
    .onehot (rb_onehot)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    mem_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_T0;
      ST_T0: begin
        state_d    = ST_T1;
        wait_cnt_d = '0;
      end
      ST_T1: begin
        // A late ack arriving on the timeout edge still completes the fetch
        if (mem_ack) begin
          state_d    = ST_T2;
          wait_cnt_d = '0;
        end else if (wait_next == WAIT_LIMIT) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_next;
        end
      end
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        if (op_legal) begin
          state_d = ST_T4;
        end else begin
          state_d   = ST_IDLE;
          illegal_d = 1'b1;
        end
      end
      ST_T4: state_d = ST_T5;
      ST_T5: state_d = ST_T6;
      ST_T6: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // T3 reads ir directly: IR is only loaded on the T2->T3 edge
  always_comb begin
    enable          = '0;
    busSelect       = '0;
    MR_Read         = 1'b0;
    Control_Signals = ALU_NOP;
    inc_pc          = 1'b0;
    case (state_q)
      ST_T0: begin
        busSelect[SEL_PC] = 1'b1;
        enable[EN_MAR]    = 1'b1;
        enable[EN_PC]     = 1'b1;
        inc_pc            = 1'b1;
      end
      ST_T1: begin
        MR_Read        = 1'b1;
        enable[EN_MDR] = 1'b1;
      end
      ST_T2: begin
        busSelect[SEL_MDR] = 1'b1;
        enable[EN_IR]      = 1'b1;
      end
      ST_T3: begin
        if (op_legal) begin
          busSelect[15:0] = ra_onehot;
          enable[EN_Y]    = 1'b1;
        end
      end
      ST_T4: begin
        busSelect[15:0] = rb_onehot;
        enable[EN_Z]    = 1'b1;
        Control_Signals = is_mul ? ALU_MUL : ALU_DIV;
      end
      ST_T5: begin
        busSelect[SEL_ZLO] = 1'b1;
        enable[EN_LO]      = 1'b1;
      end
      ST_T6: begin
        busSelect[SEL_ZHI] = 1'b1;
        enable[EN_HI]      = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign illegal_op = illegal_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_muldiv_control_seq.sv
// Scoreboard bench for the MUL/DIV sequencer: each instruction pushes its expected
// per-cycle control outputs; a negedge monitor pops and compares them.
module tb_muldiv_control_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] enable, busSelect;
  logic        MR_Read, inc_pc, busy, done, illegal_op, mem_err;
  logic [3:0]  Control_Signals;

  muldiv_control_seq #(.MEM_WAIT_MAX(15)) dut (
    .clk             (clk),
    .clr             (clr),
    .start           (start),
    .ir              (ir),
    .mem_ack         (mem_ack),
    .enable          (enable),
    .busSelect       (busSelect),
    .MR_Read         (MR_Read),
    .Control_Signals (Control_Signals),
    .inc_pc          (inc_pc),
    .busy            (busy),
    .done            (done),
    .illegal_op      (illegal_op),
    .mem_err         (mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flags = {MR_Read, inc_pc, busy, done, illegal_op, mem_err}
  typedef struct {
    int          cyc;
    logic [31:0] en;
    logic [31:0] bs;
    logic [3:0]  cs;
    logic [5:0]  fl;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  function automatic void push_exp(input int c, input logic [31:0] en, input logic [31:0] bs,
                                   input logic [3:0] cs, input logic [5:0] fl);
    exp_t e;
    e.cyc = c; e.en = en; e.bs = bs; e.cs = cs; e.fl = fl;
    expq.push_back(e);
  endfunction

  // Expected timeline for one instruction whose start is presented in cycle c.
  // d = extra T1 cycles before ack; tmo = ack never comes. Returns the final (pulse) cycle.
  function automatic int build_expect(input int c, input logic [31:0] irv, input int d, input bit tmo);
    int t, n, ra, rb;
    logic [4:0] op;
    op = irv[31:27];
    ra = int'(irv[26:23]);
    rb = int'(irv[22:19]);
    t  = c + 1;
    push_exp(t++, 32'h0210_0000, 32'h0010_0000, 4'd0, 6'b011000);
    n = tmo ? 15 : d + 1;
    for (int i = 0; i < n; i++)
      push_exp(t++, 32'h0020_0000, 32'h0, 4'd0, 6'b101000);
    if (tmo) begin
      push_exp(t, 32'h0, 32'h0, 4'd0, 6'b000001);
      return t;
    end
    push_exp(t++, 32'h0080_0000, 32'h0020_0000, 4'd0, 6'b001000);
    if (op != 5'h0F && op != 5'h10) begin
      push_exp(t++, 32'h0, 32'h0, 4'd0, 6'b001000);
      push_exp(t, 32'h0, 32'h0, 4'd0, 6'b000010);
      return t;
    end
    push_exp(t++, 32'h0800_0000, 32'd1 << ra, 4'd0, 6'b001000);
    push_exp(t++, 32'h0100_0000, 32'd1 << rb, (op == 5'h0F) ? 4'd11 : 4'd12, 6'b001000);
    push_exp(t++, 32'h0002_0000, 32'h0008_0000, 4'd0, 6'b001000);
    push_exp(t++, 32'h0001_0000, 32'h0004_0000, 4'd0, 6'b001000);
    push_exp(t, 32'h0, 32'h0, 4'd0, 6'b000100);
    return t;
  endfunction

  // Monitor: compares every cycle against the scoreboard, or against idle when nothing is due
  always @(negedge clk) begin
    exp_t e;
    check("bus_onehot0", 32'($onehot0(busSelect)), 32'd1);
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_expectation: due cycle %0d, now %0d", expq[0].cyc, cyc);
      void'(expq.pop_front());
    end
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      check("enable", enable, e.en);
      check("busSelect", busSelect, e.bs);
      check("Control_Signals", 32'(Control_Signals), 32'(e.cs));
      check("flags", 32'({MR_Read, inc_pc, busy, done, illegal_op, mem_err}), 32'(e.fl));
    end else begin
      check("idle_outputs", enable | busSelect, 32'h0);
      check("idle_flags", 32'({MR_Read, inc_pc, busy, done, illegal_op, mem_err, Control_Signals}), 32'h0);
    end
  end

  task automatic run_instr(input string name, input logic [31:0] irv, input int d,
                           input bit tmo, input bit hold);
    int c, last;
    c       = cyc;
    ir      = irv;
    start   = 1'b1;
    mem_ack = 1'b0;
    last    = build_expect(c, irv, d, tmo);
    while (cyc < last) begin
      @(posedge clk); #1;
      start   = hold;
      mem_ack = !tmo && (cyc == c + 2 + d);
    end
    $display("txn %s ir=%h start_cycle=%0d end_cycle=%0d", name, irv, c, last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, last;
    #2;
    check("reset_enable", enable | busSelect, 32'h0);
    check("reset_flags", 32'({MR_Read, inc_pc, busy, done, illegal_op, mem_err, Control_Signals}), 32'h0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;

    run_instr("mul_r6_r7", 32'h7B38_0000, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_instr("div_r1_r7_ack3", 32'h80B8_0000, 2, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_instr("timeout", 32'h7B38_0000, 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    run_instr("illegal_op3", 32'h1800_0000, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_instr("b2b_mul", 32'h7B38_0000, 0, 1'b0, 1'b1);
    run_instr("b2b_div", 32'h80B8_0000, 1, 1'b0, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;

    // Asynchronous clear in the middle of T4
    c     = cyc;
    ir    = 32'h7B38_0000;
    start = 1'b1;
    last  = build_expect(c, ir, 0, 1'b0);
    while (expq.size() > 0 && expq[$].cyc > c + 5) void'(expq.pop_back());
    repeat (5) begin
      @(posedge clk); #1;
      start   = 1'b0;
      mem_ack = (cyc == c + 2);
    end
    @(negedge clk); #1;
    clr = 1'b0;
    #1;
    check("clr_enable", enable | busSelect, 32'h0);
    check("clr_flags", 32'({MR_Read, inc_pc, busy, done, illegal_op, mem_err, Control_Signals}), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    check("clr_held_busy", 32'(busy), 32'h0);
    @(negedge clk); #1;
    clr = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("txn clr_mid_t4 ir=%h start_cycle=%0d aborted_after_cycle=%0d planned_end=%0d", ir, c, c + 5, last);

    check("queue_drained", 32'(expq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
